cr_prefix_fe_cnt: RTL and testbench
===================================

Name: cr_prefix_fe_cnt

Overview:
Downstream consumer of the per-character feature comparators in the prefix engine. Takes the registered match bits from NUM_FE comparator lanes and accumulates a per-feature match count and a character count over one prefix window. At window end it presents the count vector to the prefix feature-vector builder through a valid/ready handshake. Windows end on an explicit last marker or are force-closed at MAX_CHARS.

Parameters:
NUM_FE, 8, number of feature comparator lanes consumed.
CNT_W, 11, width of each per-feature count and of the character count.
MAX_CHARS, 1024, window truncation length; legal range 1 to 2^CNT_W-1.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
fe_char_valid  in  1  char presented to the comparator lanes this cycle
fe_char_last  in  1  qualifies fe_char_valid; last char of the prefix window
fe_char_match  in  NUM_FE  registered comparator outputs; bit i belongs to the char presented one cycle earlier
fe_flush  in  1  synchronous abort of the current window
fe_stall  out  1  output register occupied; upstream must not present a last char
fe_cnt_valid  out  1  count record available
fe_cnt_ready  in  1  downstream accepts the record
fe_cnt_data  out  NUM_FE*CNT_W  lane i count at bits [i*CNT_W +: CNT_W]
fe_cnt_nchars  out  CNT_W  chars in the window
fe_cnt_trunc  out  1  window closed by MAX_CHARS, not by last
fe_err_overrun  out  1  sticky; a window closed while the output was held

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, accumulators 0, alignment regs 0, FSM EMPTY. Priority: rst > fe_flush > normal operation.
- Alignment stage: valid_d/last_d register fe_char_valid/fe_char_last, so they line up with fe_char_match. fe_char_match is ignored when valid_d=0.
- Accumulate on each cycle with valid_d=1:
  - acc[i] += fe_char_match[i], saturating at 2^CNT_W-1.
  - nchars += 1, saturating.
- Window close condition: valid_d and (last_d or nchars+1 == MAX_CHARS).
  - Close value = acc + current match (saturated), nchars+1.
  - trunc = ~last_d.
  - Accumulators clear in the same edge; the next char starts a new window with no bubble.
- Latency: char with fe_char_last presented in cycle T gives fe_cnt_valid=1 in cycle T+2.
- Output FSM:
  - EMPTY: on close, load output regs and go to FULL.
  - FULL: hold outputs stable while fe_cnt_ready=0. On fe_cnt_ready=1 with no close, go to EMPTY and drop fe_cnt_valid next cycle. On fe_cnt_ready=1 with a close in the same cycle, reload the new record and stay FULL.
  - FULL with fe_cnt_ready=0 and a close: overrun. Set fe_err_overrun (sticky until rst); the new record is dropped; accumulators still clear; held record unchanged.
- fe_stall = (state == FULL), registered. Non-last chars may continue while stalled and accumulate normally.
- fe_flush: clears accumulators, nchars, valid_d and last_d. A char aligned in the flush cycle is discarded. The output register and FSM are unaffected.
- Reset mid-window: partial counts are discarded; no record is emitted.
- fe_cnt_data, fe_cnt_nchars and fe_cnt_trunc are 0 whenever the FSM is EMPTY.

Decomposition:
- cr_prefixPKG:
  - FE_NUM and FE_CNT_W constants.
  - typedef fe_cnt_vec_t (packed array [FE_NUM] of logic [FE_CNT_W-1:0]).
  - typedef fe_cnt_rec_t struct {counts, nchars, trunc}.
  - enum fe_cnt_state_e {FE_CNT_EMPTY, FE_CNT_FULL}.
- Sub-module cr_prefix_fe_cnt_lane: one saturating accumulator with clear/inc/close-value output, instantiated NUM_FE times. The nchars counter reuses the same lane with inc tied to valid_d.

Test Plan:
- Basic window: 4 chars, last on the 4th; lane0 match on all chars, lane1 on chars 3-4; ready=1 -> cycle T+2: valid=1, lane0=4, lane1=2, other lanes 0, nchars=4, trunc=0; valid drops next cycle.
- Backpressure: same window with ready=0 for 5 cycles -> fe_stall and fe_cnt_valid high, data stable for 5 cycles. Ready=1 -> EMPTY next cycle, stall=0.
- Overrun: hold ready=0, present a second 2-char window with last -> fe_err_overrun=1 (stays 1); outputs keep the first window (nchars=4). After accept, no second record appears.
- Truncation (MAX_CHARS=8): 10 chars, last on the 10th, all lane0 matches -> first record nchars=8, lane0=8, trunc=1; second record nchars=2, lane0=2, trunc=0.
- Saturation plus back-to-back (CNT_W=3, MAX_CHARS=7): window of 7 matching chars, then a window of 2 chars with ready=1 and close coinciding with accept -> lane0=7 then lane0=2; records contiguous with no bubble, no overrun.
- Flush/reset: 3 chars, fe_flush, then 2 chars with last -> record nchars=2. Repeat with rst asserted mid-window -> no record, all outputs 0, err cleared.

Source files
------------

// File: rtl/cr_prefix_fe_cnt_pkg.sv
// cr_prefix_fe_cnt_pkg
// Shared constants and types for the prefix-engine feature counter.
// No ports. Provides the default lane count and count width, the record
// layout handed to the feature-vector builder, and the output-register
// state encoding.
package cr_prefix_fe_cnt_pkg;

  localparam int FE_NUM   = 8;
  localparam int FE_CNT_W = 11;

  typedef logic [FE_NUM-1:0][FE_CNT_W-1:0] fe_cnt_vec_t;

  typedef struct packed {
    fe_cnt_vec_t           counts;
    logic [FE_CNT_W-1:0]   nchars;
    logic                  trunc;
  } fe_cnt_rec_t;

  typedef enum logic {
    FE_CNT_EMPTY = 1'b0,
    FE_CNT_FULL  = 1'b1
  } fe_cnt_state_e;

endpackage

// File: rtl/cr_prefix_fe_cnt_lane.sv
// cr_prefix_fe_cnt_lane
// One saturating window accumulator.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr_i         clear the accumulator at this edge (window close or flush)
//   inc_en_i      an aligned char is present this cycle
//   inc_i         add one for this char (when inc_en_i)
//   close_val_o   accumulator plus this cycle's increment, saturated; this is
//                 the value a record takes if the window closes now
module cr_prefix_fe_cnt_lane #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_en_i,
  input  logic         inc_i,
  output logic [W-1:0] close_val_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] sum;

  // Saturating add: once all ones, the count sticks at its maximum.
  always_comb begin
    sum = acc_q;
    if (inc_en_i && inc_i && (acc_q != {W{1'b1}})) begin
      sum = acc_q + W'(1);
    end
  end

  // Clear wins over increment so a closing char starts the next window at 0.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (inc_en_i) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign close_val_o = sum;

endmodule

// File: rtl/cr_prefix_fe_cnt.sv
// cr_prefix_fe_cnt
// Accumulates per-feature match counts and a char count over one prefix
// window and hands the result to the feature-vector builder via valid/ready.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   fe_char_valid   char presented to the comparator lanes this cycle
//   fe_char_last    last char of the window (qualified by fe_char_valid)
//   fe_char_match   comparator results for the char presented one cycle ago
//   fe_flush        abort the current window
//   fe_stall        output register occupied; do not present a last char
//   fe_cnt_valid    record available; fe_cnt_ready accepts it
//   fe_cnt_data     lane i count at [i*CNT_W +: CNT_W]
//   fe_cnt_nchars   chars in the window
//   fe_cnt_trunc    window was force-closed at MAX_CHARS
//   fe_err_overrun  sticky: a window closed while a record was still held
module cr_prefix_fe_cnt
  import cr_prefix_fe_cnt_pkg::*;
#(
  parameter int NUM_FE    = FE_NUM,
  parameter int CNT_W     = FE_CNT_W,
  parameter int MAX_CHARS = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fe_char_valid,
  input  logic                      fe_char_last,
  input  logic [NUM_FE-1:0]         fe_char_match,
  input  logic                      fe_flush,
  output logic                      fe_stall,
  output logic                      fe_cnt_valid,
  input  logic                      fe_cnt_ready,
  output logic [NUM_FE*CNT_W-1:0]   fe_cnt_data,
  output logic [CNT_W-1:0]          fe_cnt_nchars,
  output logic                      fe_cnt_trunc,
  output logic                      fe_err_overrun
);

  logic                    charValid_q;
  logic                    charLast_q;
  logic [NUM_FE*CNT_W-1:0] closeData;
  logic [CNT_W-1:0]        closeNchars;
  logic                    closeEv;
  logic                    accClr;

  fe_cnt_state_e           state_q, state_d;
  logic [NUM_FE*CNT_W-1:0] cntData_q, cntData_d;
  logic [CNT_W-1:0]        cntNchars_q, cntNchars_d;
  logic                    cntTrunc_q, cntTrunc_d;
  logic                    overrun_q, overrun_d;

  // Delay valid/last one cycle so they line up with the registered match bits.
  // A flush discards both the aligned char and the one being presented.
  always_ff @(posedge clk) begin
    if (rst || fe_flush) begin
      charValid_q <= 1'b0;
      charLast_q  <= 1'b0;
    end else begin
      charValid_q <= fe_char_valid;
      charLast_q  <= fe_char_last;
    end
  end

  for (genvar i = 0; i < NUM_FE; i++) begin : g_lane
    cr_prefix_fe_cnt_lane #(.W(CNT_W)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (accClr),
      .inc_en_i    (charValid_q),
      .inc_i       (fe_char_match[i]),
      .close_val_o (closeData[i*CNT_W +: CNT_W])
    );
  end

  cr_prefix_fe_cnt_lane #(.W(CNT_W)) u_nchars (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (accClr),
    .inc_en_i    (charValid_q),
    .inc_i       (1'b1),
    .close_val_o (closeNchars)
  );

  // closeNchars already includes the current char, so it equals MAX_CHARS on
  // the char that fills the window.
  assign closeEv = charValid_q && !fe_flush &&
                   (charLast_q || (closeNchars == CNT_W'(MAX_CHARS)));
  assign accClr  = fe_flush || closeEv;

  // Output register control. Accept and a new close in the same cycle reload
  // directly so back-to-back records have no bubble; a close while the held
  // record is not being accepted is dropped and flagged.
  always_comb begin
    state_d     = state_q;
    cntData_d   = cntData_q;
    cntNchars_d = cntNchars_q;
    cntTrunc_d  = cntTrunc_q;
    overrun_d   = overrun_q;
    case (state_q)
      FE_CNT_EMPTY: begin
        if (closeEv) begin
          state_d     = FE_CNT_FULL;
          cntData_d   = closeData;
          cntNchars_d = closeNchars;
          cntTrunc_d  = !charLast_q;
        end
      end
      FE_CNT_FULL: begin
        if (fe_cnt_ready) begin
          if (closeEv) begin
            cntData_d   = closeData;
            cntNchars_d = closeNchars;
            cntTrunc_d  = !charLast_q;
          end else begin
            state_d     = FE_CNT_EMPTY;
            cntData_d   = '0;
            cntNchars_d = '0;
            cntTrunc_d  = 1'b0;
          end
        end else if (closeEv) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = FE_CNT_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FE_CNT_EMPTY;
      cntData_q   <= '0;
      cntNchars_q <= '0;
      cntTrunc_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntData_q   <= cntData_d;
      cntNchars_q <= cntNchars_d;
      cntTrunc_q  <= cntTrunc_d;
      overrun_q   <= overrun_d;
    end
  end

  assign fe_stall       = (state_q == FE_CNT_FULL);
  assign fe_cnt_valid   = (state_q == FE_CNT_FULL);
  assign fe_cnt_data    = cntData_q;
  assign fe_cnt_nchars  = cntNchars_q;
  assign fe_cnt_trunc   = cntTrunc_q;
  assign fe_err_overrun = overrun_q;

endmodule

// File: tb/tb_cr_prefix_fe_cnt.sv
// tb_cr_prefix_fe_cnt
// Bench for cr_prefix_fe_cnt with NUM_FE=8, CNT_W=3, MAX_CHARS=7 so that the
// window-length and count-width limits are reachable in short runs.
module tb_cr_prefix_fe_cnt;

  localparam int NFE  = 8;
  localparam int CW   = 3;
  localparam int MAXC = 7;
  localparam int MAXV = (1 << CW) - 1;

  logic              clk;
  logic              rst;
  logic              fe_char_valid;
  logic              fe_char_last;
  logic [NFE-1:0]    fe_char_match;
  logic              fe_flush;
  logic              fe_stall;
  logic              fe_cnt_valid;
  logic              fe_cnt_ready;
  logic [NFE*CW-1:0] fe_cnt_data;
  logic [CW-1:0]     fe_cnt_nchars;
  logic              fe_cnt_trunc;
  logic              fe_err_overrun;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 0;

  // Match bits belong to the previous char, so the driver holds them one call.
  bit             prevValid = 0;
  logic [NFE-1:0] prevMatch = '0;

  // Behavioural model state: the open window as integer counts, plus the
  // record currently offered downstream.
  bit mPv, mPl;
  int mCnt[NFE];
  int mN;
  bit mFull;
  int mOut[NFE];
  int mOutN;
  bit mOutT;
  bit mErr;
  bit mClose;
  int mRc[NFE];
  int mRn;
  bit mRt;

  // Records the DUT handed over (sampled at the accepting edge).
  int recN[$];
  int recL0[$];
  int recL1[$];
  int recT[$];

  cr_prefix_fe_cnt #(.NUM_FE(NFE), .CNT_W(CW), .MAX_CHARS(MAXC)) dut (
    .clk            (clk),
    .rst            (rst),
    .fe_char_valid  (fe_char_valid),
    .fe_char_last   (fe_char_last),
    .fe_char_match  (fe_char_match),
    .fe_flush       (fe_flush),
    .fe_stall       (fe_stall),
    .fe_cnt_valid   (fe_cnt_valid),
    .fe_cnt_ready   (fe_cnt_ready),
    .fe_cnt_data    (fe_cnt_data),
    .fe_cnt_nchars  (fe_cnt_nchars),
    .fe_cnt_trunc   (fe_cnt_trunc),
    .fe_err_overrun (fe_err_overrun)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    mClose = 0;
    if (rst) begin
      for (int i = 0; i < NFE; i++) begin mCnt[i] = 0; mOut[i] = 0; end
      mN = 0; mPv = 0; mPl = 0; mFull = 0; mOutN = 0; mOutT = 0; mErr = 0;
    end else begin
      if (fe_flush) begin
        for (int i = 0; i < NFE; i++) mCnt[i] = 0;
        mN = 0; mPv = 0; mPl = 0;
      end else begin
        if (mPv) begin
          for (int i = 0; i < NFE; i++) begin
            mCnt[i] = mCnt[i] + int'(fe_char_match[i]);
            if (mCnt[i] > MAXV) mCnt[i] = MAXV;
          end
          mN = (mN + 1 > MAXV) ? MAXV : mN + 1;
          if (mPl || mN == MAXC) begin
            mClose = 1;
            mRc = mCnt; mRn = mN; mRt = !mPl;
            for (int i = 0; i < NFE; i++) mCnt[i] = 0;
            mN = 0;
          end
        end
        mPv = fe_char_valid;
        mPl = fe_char_last;
      end
      if (mFull && fe_cnt_ready) mFull = 0;
      if (mClose) begin
        if (!mFull) begin
          mFull = 1; mOut = mRc; mOutN = mRn; mOutT = mRt;
        end else begin
          mErr = 1;
        end
      end
    end
  end

  // Capture every record the DUT hands over at an accepting edge.
  always @(posedge clk) begin
    if (!rst && fe_cnt_valid && fe_cnt_ready) begin
      recN.push_back(int'(fe_cnt_nchars));
      recL0.push_back(int'(fe_cnt_data[0 +: CW]));
      recL1.push_back(int'(fe_cnt_data[CW +: CW]));
      recT.push_back(int'(fe_cnt_trunc));
    end
  end

  task automatic checkEq(input string name, input longint act, input longint exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic checkOutput();
    logic [NFE*CW-1:0] expData;
    expData = '0;
    for (int i = 0; i < NFE; i++) if (mFull) expData[i*CW +: CW] = CW'(mOut[i]);
    checkEq("valid", fe_cnt_valid, mFull);
    checkEq("stall", fe_stall, mFull);
    checkEq("data", fe_cnt_data, expData);
    checkEq("nchars", fe_cnt_nchars, mFull ? mOutN : 0);
    checkEq("trunc", fe_cnt_trunc, mFull ? mOutT : 0);
    checkEq("overrun", fe_err_overrun, mErr);
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic l, input logic [NFE-1:0] m,
                               input logic fl, input logic rdy);
    @(negedge clk);
    fe_char_valid = v;
    fe_char_last  = l;
    fe_flush      = fl;
    fe_cnt_ready  = rdy;
    fe_char_match = prevValid ? prevMatch : NFE'($urandom);
    prevValid     = v && !fl;
    prevMatch     = m;
  endtask

  task automatic sendChars(input int n, input bit withLast, input logic [NFE-1:0] m, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, withLast && (i == n - 1), m, 1'b0, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, rdy);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1; fe_char_valid = 0; fe_char_last = 0; fe_flush = 0;
    fe_char_match = '0; prevValid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic checkRec(input string name, input int idx, input int n, input int l0,
                          input int l1, input int t);
    if (idx < recN.size()) begin
      checkEq({name, " nchars"}, recN[idx], n);
      checkEq({name, " lane0"}, recL0[idx], l0);
      checkEq({name, " lane1"}, recL1[idx], l1);
      checkEq({name, " trunc"}, recT[idx], t);
    end
  endtask

  int base;

  initial begin
    rst = 1; fe_char_valid = 0; fe_char_last = 0; fe_char_match = '0;
    fe_flush = 0; fe_cnt_ready = 0;
    repeat (2) @(negedge clk);
    checkEn = 1;
    @(negedge clk);
    checkEq("reset valid", fe_cnt_valid, 0);
    checkEq("reset data", fe_cnt_data, 0);
    checkEq("reset overrun", fe_err_overrun, 0);
    rst = 0;

    // Basic window: lane0 on all 4 chars, lane1 on chars 3-4.
    $display("[TB] basic window");
    sendChars(2, 0, 8'h01, 1); sendChars(2, 1, 8'h03, 1);
    idle(2, 1);
    checkEq("basic valid", fe_cnt_valid, 1);
    checkEq("basic data", fe_cnt_data, 24'd20);
    checkEq("basic nchars", fe_cnt_nchars, 4);
    checkEq("basic trunc", fe_cnt_trunc, 0);
    idle(1, 0);
    checkEq("basic valid drop", fe_cnt_valid, 0);

    // Backpressure: record held stable for 5 cycles.
    $display("[TB] backpressure");
    sendChars(2, 0, 8'h01, 0); sendChars(2, 1, 8'h03, 0);
    idle(1, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 0);
      checkEq("hold valid", fe_cnt_valid, 1);
      checkEq("hold stall", fe_stall, 1);
      checkEq("hold data", fe_cnt_data, 24'd20);
      checkEq("hold nchars", fe_cnt_nchars, 4);
    end
    idle(1, 1);
    idle(1, 0);
    checkEq("release valid", fe_cnt_valid, 0);
    checkEq("release stall", fe_stall, 0);

    // Truncation at MAX_CHARS=7 of a 10-char window.
    $display("[TB] truncation");
    base = recN.size();
    sendChars(10, 1, 8'h01, 1);
    idle(4, 1);
    checkEq("trunc rec count", recN.size() - base, 2);
    checkRec("trunc rec0", base, 7, 7, 0, 1);
    checkRec("trunc rec1", base + 1, 3, 3, 0, 0);

    // Full-width count then back-to-back window whose close meets the accept.
    $display("[TB] saturation and back-to-back");
    base = recN.size();
    sendChars(7, 1, 8'h01, 0);
    sendChars(2, 1, 8'h01, 0);
    idle(2, 1);
    idle(2, 0);
    checkEq("b2b rec count", recN.size() - base, 2);
    checkRec("b2b rec0", base, 7, 7, 0, 0);
    checkRec("b2b rec1", base + 1, 2, 2, 0, 0);
    checkEq("b2b overrun", fe_err_overrun, 0);

    // Overrun: second window closes while the first is still held.
    $display("[TB] overrun");
    base = recN.size();
    sendChars(2, 0, 8'h01, 0); sendChars(2, 1, 8'h03, 0);
    idle(1, 0);
    sendChars(2, 1, 8'h04, 0);
    idle(2, 0);
    checkEq("ovr flag", fe_err_overrun, 1);
    checkEq("ovr held nchars", fe_cnt_nchars, 4);
    checkEq("ovr held data", fe_cnt_data, 24'd20);
    idle(1, 1);
    idle(3, 0);
    checkEq("ovr no second", fe_cnt_valid, 0);
    checkEq("ovr sticky", fe_err_overrun, 1);
    checkEq("ovr rec count", recN.size() - base, 1);

    // Flush discards the partial window.
    $display("[TB] flush");
    base = recN.size();
    sendChars(3, 0, 8'h05, 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    sendChars(2, 1, 8'h02, 1);
    idle(3, 1);
    checkEq("flush rec count", recN.size() - base, 1);
    checkRec("flush rec", base, 2, 0, 2, 0);

    // Reset in the middle of a window emits nothing and clears the error.
    $display("[TB] reset mid-window");
    base = recN.size();
    sendChars(3, 0, 8'hff, 1);
    doReset();
    idle(4, 1);
    checkEq("rst rec count", recN.size() - base, 0);
    checkEq("rst valid", fe_cnt_valid, 0);
    checkEq("rst data", fe_cnt_data, 0);
    checkEq("rst overrun", fe_err_overrun, 0);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) < 3) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 1, NFE'($urandom),
                      $urandom_range(0, 99) < 2, $urandom_range(0, 9) < 6);
      end
    end
    idle(6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
